mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MIPS MEM stage, directly downstream of the EX stage. Holds the EX/MEM pipeline register and a
//  word-wide data memory with configurable wait states. Also holds the MEM/WB register.
//  Supplies forwarding sources (EX/MEM and MEM/WB) back to EX. Drives stall upstream while an access is pending.
// PARAMETERS
//  ADDR_W       8   word-address width; depth = 2**ADDR_W words
//  MEM_LATENCY  2   extra wait-state cycles per load/store (0 = single-cycle)
// PORTS
//  clock           in   1   rising-edge clock
//  reset           in   1   asynchronous, active-high; clears all state
//  EXMWB           in   2   WB ctrl from EX: [0]=RegWrite, [1]=MemtoReg
//  EXMM            in   3   M ctrl from EX: [0]=MemWrite, [1]=MemRead, [2]=Branch (ignored here)
//  EXALUOut        in   32  ALU result / byte address
//  EXMWriteDataIn  in   32  store data
//  regtopass       in   5   destination register
//  stall           out  1   freeze PC, IF/ID, ID/EX and EX/MEM this cycle
//  misalign        out  1   1-cycle pulse: an access completed with addr[1:0]!=0
//  MEMALUOut       out  32  EX/MEM ALUOut (forwarding source)
//  EXMEMRegRd      out  5   EX/MEM destination register
//  EXMEM_RegWrite  out  2   EX/MEM WB ctrl (bit0 = RegWrite)
//  MEMWBRegRd      out  5   MEM/WB destination register
//  MEMWB_RegWrite  out  2   MEM/WB WB ctrl (bit0 = RegWrite)
//  datatowrite     out  32  write-back value: MemtoReg ? load data : ALUOut (from MEM/WB)
// BEHAVIOUR
//  Reset: all EX/MEM and MEM/WB fields are 0 (bubble), FSM=IDLE, counter=0, stall=0, misalign=0.
//   Memory contents are NOT reset.
//  EX/MEM reg: loads EX outputs on each rising edge with stall=0; holds when stall=1.
//  Access = MemRead|MemWrite in EX/MEM. If both bits are set, it is treated as read+write:
//   the old word is read and the new word is written.
//  Word index = MEMALUOut[ADDR_W+1:2]; upper bits ignored (address wraps); addr[1:0] ignored except misalign.
//  FSM, MEM_LATENCY=L>0:
//   IDLE -> WAIT when a new access enters EX/MEM; cnt<=L-1.
//    stall is driven combinationally as 1 during the access's first cycle (IDLE with access in EX/MEM).
//   WAIT: stall=1; cnt decrements each cycle. At cnt==0 in WAIT -> DONE.
//   DONE: stall=0; this cycle's edge commits the access -> IDLE.
//   Result: each access spends L+1 cycles in MEM and stalls upstream for exactly L cycles.
//  L=0: no WAIT/DONE; every access commits at the first edge; stall is never asserted.
//  Commit edge, all on one edge:
//   - write mem[idx] <= store data (if MemWrite);
//   - MEM/WB <= {WB ctrl, Rd, ALUOut, mem[idx] old value};
//   - EX/MEM loads the next instruction;
//   - misalign pulses for 1 cycle after the edge if addr[1:0]!=0.
//  Non-access instructions commit on every non-stalled edge.
//  While stall=1, MEM/WB loads a bubble (WB ctrl=0, Rd=0, data=0) each edge, so no double write-back.
//  Forwarding outputs are direct register taps (no combinational path from inputs).
//  datatowrite is a combinational mux on MEM/WB only.
//  Back-to-back accesses: a second access entering on the commit edge starts a fresh IDLE->WAIT sequence;
//   there is no idle gap.
//  Reset asserted mid-WAIT: the access is abandoned, no memory write occurs, stall drops immediately (async).
//  Branch bit (EXMM[2]) is latched but has no effect.
// TESTING
//  L=2; SW addr 0x10 data 0xDEADBEEF, then LW Rd=5 addr 0x10
//   -> stall high 2 cycles per access; MEMWBRegRd=5, datatowrite=0xDEADBEEF, MEMWB_RegWrite=2'b11.
//  L=0; ADD result 0x1234 Rd=3 followed by LW
//   -> stall never 1; MEMALUOut=0x1234 and EXMEMRegRd=3 one cycle after EX, then MEM/WB next cycle.
//  L=3; LW during stall -> EX/MEM inputs changed by bench are ignored.
//   -> MEM/WB shows 3 bubbles (RegWrite=0), then the load result.
//  ADDR_W=8; SW to 0x400 then LW from 0x000 -> returns stored data (wrap). LW addr 0x13 -> misalign pulse 1 cycle.
//  L=2; assert reset in 2nd WAIT cycle of SW 0x20<=0x55 -> stall=0 at once, all outputs 0.
//   A later LW 0x20 does not return 0x55.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS MEM pipeline stage.
// Holds the EX/MEM register, a word-wide data memory with a configurable number
// of wait states, and the MEM/WB register. It also feeds forwarding taps back to
// EX and stalls upstream while a load or store is still in progress.
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  EXMWB,
  input  logic [2:0]  EXMM,
  input  logic [31:0] EXALUOut,
  input  logic [31:0] EXMWriteDataIn,
  input  logic [4:0]  regtopass,
  output logic        stall,
  output logic        misalign,
  output logic [31:0] MEMALUOut,
  output logic [4:0]  EXMEMRegRd,
  output logic [1:0]  EXMEM_RegWrite,
  output logic [4:0]  MEMWBRegRd,
  output logic [1:0]  MEMWB_RegWrite,
  output logic [31:0] datatowrite
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;

  // EX/MEM pipeline register
  logic [1:0]  exmem_wb_reg;
  logic [2:0]  exmem_m_reg;
  logic [31:0] exmem_alu_reg;
  logic [31:0] exmem_wd_reg;
  logic [4:0]  exmem_rd_reg;

  // MEM/WB pipeline register; the load word lives in rd_data_reg next to the RAM
  logic [1:0]  memwb_wb_reg;
  logic [4:0]  memwb_rd_reg;
  logic [31:0] memwb_alu_reg;
  logic [31:0] rd_data_reg;
  logic        misalign_reg;

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic              access;
  logic              commit;
  logic [ADDR_W-1:0] idx;
  logic              unused_branch;

  assign access        = exmem_m_reg[0] | exmem_m_reg[1];
  assign idx           = exmem_alu_reg[ADDR_W+1:2];
  // Every non-stalled edge retires whatever sits in EX/MEM.
  assign commit        = ~stall;
  // The branch bit rides along in EX/MEM but nothing in this stage consumes it.
  assign unused_branch = exmem_m_reg[2];

  // Wait-state sequencer: the IDLE cycle of a new access plus the WAIT cycles
  // stall for MEM_LATENCY cycles in total; DONE is the non-stalled commit cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MEM_LATENCY > 0 && access) begin
          stall      = 1'b1;
          cnt_next   = 8'(MEM_LATENCY - 1);
          state_next = (MEM_LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall    = 1'b1;
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg <= 8'd1) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // EX/MEM register: load from EX unless the pipe is frozen
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exmem_wb_reg  <= 2'b0;
      exmem_m_reg   <= 3'b0;
      exmem_alu_reg <= 32'b0;
      exmem_wd_reg  <= 32'b0;
      exmem_rd_reg  <= 5'b0;
    end else if (!stall) begin
      exmem_wb_reg  <= EXMWB;
      exmem_m_reg   <= EXMM;
      exmem_alu_reg <= EXALUOut;
      exmem_wd_reg  <= EXMWriteDataIn;
      exmem_rd_reg  <= regtopass;
    end
  end

  // MEM/WB register: retire on commit, otherwise insert a bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memwb_wb_reg  <= 2'b0;
      memwb_rd_reg  <= 5'b0;
      memwb_alu_reg <= 32'b0;
      misalign_reg  <= 1'b0;
    end else if (commit) begin
      memwb_wb_reg  <= exmem_wb_reg;
      memwb_rd_reg  <= exmem_rd_reg;
      memwb_alu_reg <= exmem_alu_reg;
      misalign_reg  <= access & (exmem_alu_reg[1:0] != 2'b00);
    end else begin
      memwb_wb_reg  <= 2'b0;
      memwb_rd_reg  <= 5'b0;
      memwb_alu_reg <= 32'b0;
      misalign_reg  <= 1'b0;
    end
  end

  // Data RAM: read-before-write on the commit edge, registered read port
  always_ff @(posedge clock) begin
    if (commit) begin
      if (exmem_m_reg[0]) mem[idx] <= exmem_wd_reg;
      rd_data_reg <= mem[idx];
    end
  end

  assign misalign       = misalign_reg;
  assign MEMALUOut      = exmem_alu_reg;
  assign EXMEMRegRd     = exmem_rd_reg;
  assign EXMEM_RegWrite = exmem_wb_reg;
  assign MEMWBRegRd     = memwb_rd_reg;
  assign MEMWB_RegWrite = memwb_wb_reg;
  // rd_data_reg is only selected when MemtoReg is set, so a bubble reads as 0
  assign datatowrite    = memwb_wb_reg[1] ? rd_data_reg : memwb_alu_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (latency 2, 0, 3) share one input bus;
// each phase resets everything and checks one instance through a scoreboard.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  exmwb = '0;
  logic [2:0]  exmm = '0;
  logic [31:0] exalu = '0;
  logic [31:0] exwd = '0;
  logic [4:0]  regtopass = '0;

  logic        o_stall [3];
  logic        o_mis   [3];
  logic [31:0] o_memalu[3];
  logic [4:0]  o_exrd  [3];
  logic [1:0]  o_exrw  [3];
  logic [4:0]  o_wbrd  [3];
  logic [1:0]  o_wbrw  [3];
  logic [31:0] o_dtw   [3];

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_stage #(.ADDR_W(8), .MEM_LATENCY(gi == 0 ? 2 : (gi == 1 ? 0 : 3))) dut (
      .clock(clock), .reset(reset), .EXMWB(exmwb), .EXMM(exmm), .EXALUOut(exalu),
      .EXMWriteDataIn(exwd), .regtopass(regtopass), .stall(o_stall[gi]),
      .misalign(o_mis[gi]), .MEMALUOut(o_memalu[gi]), .EXMEMRegRd(o_exrd[gi]),
      .EXMEM_RegWrite(o_exrw[gi]), .MEMWBRegRd(o_wbrd[gi]), .MEMWB_RegWrite(o_wbrw[gi]),
      .datatowrite(o_dtw[gi])
    );
  end

  typedef struct packed {
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          sel = 0;
  int          checks = 0;
  int          fails = 0;
  int          mis_cnt = 0;
  int          n;
  int          stall_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; sample outputs 1 time unit after the edge and retire writebacks.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    if (o_mis[sel]) mis_cnt++;
    if (o_wbrw[sel][0] === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_writeback: observed rd=%0d data=%h expected none",
               o_wbrd[sel], o_dtw[sel]);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("memwb_ctrl", 32'(o_wbrw[sel]), 32'(e.wb));
        chk("memwb_rd", 32'(o_wbrd[sel]), 32'(e.rd));
        chk("datatowrite", o_dtw[sel], e.data);
      end
    end
    $display("cycle sel=%0d stall=%0b memwb_rw=%b rd=%0d dtw=%h", sel, o_stall[sel],
             o_wbrw[sel], o_wbrd[sel], o_dtw[sel]);
  endtask

  // Present one instruction to EX and hold it until it is accepted.
  // stalls = cycles it was held back; scr drives junk while the pipe is frozen.
  task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd, input bit scr,
                       output int stalls);
    int idx;
    logic s;
    idx = int'((alu >> 2) & 32'hFF);
    if (wb[0]) sb.push_back('{wb: wb, rd: rd, data: (wb[1] ? model[idx] : alu)});
    if (m[0]) model[idx] = wd;
    stalls = 0;
    for (int k = 0; k < 32; k++) begin
      exmwb = wb; exmm = m; exalu = alu; exwd = wd; regtopass = rd;
      #1;
      s = o_stall[sel];
      if (s && scr) begin
        exmwb = 2'b01; exmm = 3'b000; exalu = $urandom;
        regtopass = 5'($urandom_range(1, 31));
      end
      step();
      if (!s) break;
      stalls++;
      if (stalls > 20) begin
        chk("stall_timeout", 32'(stalls), 32'd20);
        break;
      end
    end
  endtask

  task automatic do_reset();
    exmwb = '0; exmm = '0; exalu = '0; exwd = '0; regtopass = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    sb.delete();
    model.delete();
    mis_cnt = 0;
  endtask

  initial begin
    // ---------------- latency 2 ----------------
    sel = 0;
    do_reset();
    chk("rst_stall", 32'(o_stall[0]), 32'd0);
    chk("rst_misalign", 32'(o_mis[0]), 32'd0);
    chk("rst_memaluout", o_memalu[0], 32'd0);
    chk("rst_exmem_rd", 32'(o_exrd[0]), 32'd0);
    chk("rst_memwb_rw", 32'(o_wbrw[0]), 32'd0);
    chk("rst_datatowrite", o_dtw[0], 32'd0);

    issue(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, n);   // SW 0x10
    chk("idle_no_stall", 32'(n), 32'd0);
    issue(2'b11, 3'b010, 32'h10, 32'h0, 5'd5, 1'b0, n);          // LW r5, 0x10
    chk("sw_stall_cycles", 32'(n), 32'd2);
    issue(2'b00, 3'b001, 32'h400, 32'h0BADF00D, 5'd0, 1'b0, n);  // SW 0x400 (wraps to 0)
    chk("lw_stall_cycles", 32'(n), 32'd2);
    issue(2'b11, 3'b010, 32'h000, 32'h0, 5'd6, 1'b0, n);         // LW r6, 0x000
    issue(2'b11, 3'b010, 32'h13, 32'h0, 5'd7, 1'b0, n);          // LW r7, 0x13 misaligned
    issue(2'b00, 3'b001, 32'h20, 32'h11111111, 5'd0, 1'b0, n);   // SW 0x20 baseline
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);           // bubble
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);           // bubble
    chk("misalign_pulses", 32'(mis_cnt), 32'd1);

    // SW 0x20 <= 0x55 abandoned by reset during its second stall cycle
    issue(2'b00, 3'b001, 32'h20, 32'h55, 5'd0, 1'b0, n);
    model[8] = 32'h11111111;
    exmwb = '0; exmm = '0; exalu = '0; exwd = '0; regtopass = '0;
    step();
    chk("pre_reset_stall", 32'(o_stall[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_stall", 32'(o_stall[0]), 32'd0);
    chk("async_rst_memaluout", o_memalu[0], 32'd0);
    chk("async_rst_memwb_rd", 32'(o_wbrd[0]), 32'd0);
    chk("async_rst_datatowrite", o_dtw[0], 32'd0);
    step();
    reset = 1'b0;
    issue(2'b11, 3'b010, 32'h20, 32'h0, 5'd8, 1'b0, n);          // LW r8, 0x20
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);
    chk("l2_sb_drained", 32'(sb.size()), 32'd0);

    // ---------------- latency 0 ----------------
    sel = 1;
    do_reset();
    stall_sum = 0;
    issue(2'b00, 3'b001, 32'h44, 32'hCAFEF00D, 5'd0, 1'b0, n); stall_sum += n;
    issue(2'b01, 3'b000, 32'h1234, 32'h0, 5'd3, 1'b0, n);      stall_sum += n;
    chk("l0_memaluout", o_memalu[1], 32'h1234);
    chk("l0_exmem_rd", 32'(o_exrd[1]), 32'd3);
    issue(2'b11, 3'b010, 32'h44, 32'h0, 5'd4, 1'b0, n);        stall_sum += n;
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);         stall_sum += n;
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);         stall_sum += n;
    chk("l0_stall_never", 32'(stall_sum), 32'd0);
    chk("l0_sb_drained", 32'(sb.size()), 32'd0);

    // ---------------- latency 3, junk on EX during stalls ----------------
    sel = 2;
    do_reset();
    issue(2'b00, 3'b001, 32'h30, 32'hA5A5A5A5, 5'd0, 1'b0, n);
    issue(2'b11, 3'b010, 32'h30, 32'h0, 5'd9, 1'b1, n);
    chk("l3_sw_stall_cycles", 32'(n), 32'd3);
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1, n);
    chk("l3_lw_stall_cycles", 32'(n), 32'd3);
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, n);
    chk("l3_sb_drained", 32'(sb.size()), 32'd0);
    chk("l3_no_misalign", 32'(mis_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
